// File: rtl/hdmi_tx_gearbox.sv
// 10:2 TMDS serialiser running on the 5x serial clock: loads one 10-bit word per lane
// every five cycles and shifts it out LSB-first as 2-bit slots, with a CALIB phase slip.
//
//   state | meaning
//   PH_0  | slot 0 of current word on dout, div_clk high
//   PH_1  | slot 1, div_clk high
//   PH_2  | slot 2, div_clk high
//   PH_3  | slot 3, div_clk low
//   PH_4  | slot 4, div_clk low, next word loaded unless calib
module hdmi_tx_gearbox #(
  parameter int         NUM_LANES = 3,
  parameter logic [9:0] IDLE_WORD = 10'b1101010100
) (
  input  logic                   hclkin,
  input  logic                   resetn,
  input  logic [10*NUM_LANES-1:0] word_in,
  input  logic                   word_valid,
  output logic                   word_ready,
  output logic [2*NUM_LANES-1:0] dout,
  output logic                   div_clk,
  input  logic                   calib,
  output logic                   underflow,
  output logic [7:0]             underflow_cnt
);

  typedef enum logic [2:0] {
    PH_0 = 3'd0,
    PH_1 = 3'd1,
    PH_2 = 3'd2,
    PH_3 = 3'd3,
    PH_4 = 3'd4
  } phase_t;

  phase_t phase;

  always_ff @(posedge hclkin) begin
    if (!resetn) begin
      phase <= PH_0;
    end else if (!calib) begin
      case (phase)
        PH_0:    phase <= PH_1;
        PH_1:    phase <= PH_2;
        PH_2:    phase <= PH_3;
        PH_3:    phase <= PH_4;
        PH_4:    phase <= PH_0;
        default: phase <= PH_0;
      endcase
    end
  end

  // Gated by resetn so a reset landing on PH_4 never advertises a load it will not take.
  assign word_ready = resetn && (phase == PH_4) && !calib;
  assign div_clk    = (phase == PH_0) || (phase == PH_1) || (phase == PH_2);

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    logic [9:0] shift;

    always_ff @(posedge hclkin) begin
      if (!resetn) begin
        shift <= 10'd0;
      end else if (word_ready) begin
        shift <= word_valid ? word_in[10*n +: 10] : IDLE_WORD;
      end else if (!calib) begin
        shift <= {2'b00, shift[9:2]};
      end
    end

    assign dout[2*n +: 2] = shift[1:0];
  end

  always_ff @(posedge hclkin) begin
    if (!resetn) begin
      underflow     <= 1'b0;
      underflow_cnt <= 8'd0;
    end else if (word_ready && !word_valid) begin
      underflow <= 1'b1;
      if (underflow_cnt != 8'hFF) begin
        underflow_cnt <= underflow_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_tx_gearbox.sv
// Scoreboard bench for hdmi_tx_gearbox: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hdmi_tx_gearbox;

  localparam int NL = 3;

  logic            hclkin = 1'b0;
  logic            resetn = 1'b0;
  logic [10*NL-1:0] word_in = '0;
  logic            word_valid = 1'b0;
  logic            word_ready;
  logic [2*NL-1:0] dout;
  logic            div_clk;
  logic            calib = 1'b0;
  logic            underflow;
  logic [7:0]      underflow_cnt;

  hdmi_tx_gearbox #(.NUM_LANES(NL), .IDLE_WORD(10'b1101010100)) dut (
    .hclkin        (hclkin),
    .resetn        (resetn),
    .word_in       (word_in),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .dout          (dout),
    .div_clk       (div_clk),
    .calib         (calib),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt)
  );

  always #5 hclkin = ~hclkin;

  localparam int K_DOUT = 0, K_RDY = 1, K_DIV = 2, K_UF = 3, K_CNT = 4;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   base = 0;
  int   checks = 0;
  int   failures = 0;
  logic drain_fail = 1'b0;
  logic drain_counted = 1'b0;

  always @(posedge hclkin) cyc <= cyc + 1;

  function automatic string kname(int k);
    case (k)
      K_DOUT:  return "dout";
      K_RDY:   return "word_ready";
      K_DIV:   return "div_clk";
      K_UF:    return "underflow";
      default: return "underflow_cnt";
    endcase
  endfunction

  function automatic int actual(int k);
    case (k)
      K_DOUT:  return int'(dout);
      K_RDY:   return int'(word_ready);
      K_DIV:   return int'(div_clk);
      K_UF:    return int'(underflow);
      default: return int'(underflow_cnt);
    endcase
  endfunction

  // Keeps the scoreboard sorted by cycle so tests may queue expectations in any order.
  function automatic void expect_at(int rel, int kind, int val);
    exp_t e;
    int   idx;
    e.cyc  = base + rel;
    e.kind = kind;
    e.val  = val;
    idx    = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > e.cyc) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endfunction

  always @(negedge hclkin) begin
    exp_t e;
    int   a;
    if (drain_fail && !drain_counted) begin
      drain_counted = 1'b1;
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations never reached, required 0", sb.size());
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL stale_%s: expectation for cycle %0d seen at %0d", kname(e.kind), e.cyc, cyc);
      end else begin
        a = actual(e.kind);
        if (a != e.val) begin
          failures++;
          $display("FAIL %s @rel%0d: got %0d, expected %0d", kname(e.kind), e.cyc - base, a, e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge hclkin);
    #1;
  endtask

  // Leaves the bench in cycle 0: the first cycle with resetn high.
  task automatic do_reset();
    resetn     = 1'b0;
    calib      = 1'b0;
    word_valid = 1'b0;
    tick();
    base = cyc;
    expect_at(0, K_DOUT, 0);
    expect_at(0, K_RDY, 0);
    expect_at(0, K_DIV, 1);
    expect_at(0, K_UF, 0);
    expect_at(0, K_CNT, 0);
    tick();
    resetn = 1'b1;
    base   = cyc;
  endtask

  function automatic int slot(logic [29:0] w, int j);
    logic [5:0] s;
    s = {w[20 + 2*j +: 2], w[10 + 2*j +: 2], w[2*j +: 2]};
    return int'(s);
  endfunction

  function automatic logic [29:0] stream_word(int i);
    logic [9:0] a;
    a = 10'(291 + 90*i);
    return {a + 10'h222, a + 10'h111, a};
  endfunction

  localparam logic [29:0] W1 = {10'h3FF, 10'h155, 10'h2AB};
  localparam logic [29:0] W4 = {10'h139, 10'h0E4, 10'h393};

  initial begin
    logic [29:0] w4v;
    w4v = W4;

    // Test 1: steady stream of one constant word
    do_reset();
    for (int k = 0; k < 15; k++) begin
      expect_at(k, K_RDY, (k % 5 == 4) ? 1 : 0);
      expect_at(k, K_DIV, (k % 5 <= 2) ? 1 : 0);
    end
    for (int k = 0; k < 5; k++) expect_at(k, K_DOUT, 0);
    for (int k = 5; k < 15; k++) expect_at(k, K_DOUT, (k % 5 == 0) ? 55 : 54);
    expect_at(14, K_UF, 0);
    expect_at(14, K_CNT, 0);
    word_in    = W1;
    word_valid = 1'b1;
    for (int k = 0; k < 16; k++) tick();

    // Test 2: four distinct words, contiguous slots
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 5; j++)
        expect_at(5 + 5*i + j, K_DOUT, slot(stream_word(i), j));
    expect_at(24, K_UF, 0);
    word_valid = 1'b1;
    for (int k = 0; k < 26; k++) begin
      word_in = stream_word(k / 5);
      tick();
    end

    // Test 3: one underflow load; valid dropped off-phase is ignored
    do_reset();
    for (int k = 5; k < 10; k++) expect_at(k, K_DOUT, (k == 5) ? 55 : 54);
    expect_at(9, K_UF, 0);
    expect_at(10, K_DOUT, 0);
    expect_at(11, K_DOUT, 21);
    expect_at(12, K_DOUT, 21);
    expect_at(13, K_DOUT, 21);
    expect_at(14, K_DOUT, 63);
    expect_at(10, K_UF, 1);
    expect_at(10, K_CNT, 1);
    for (int k = 15; k < 20; k++) expect_at(k, K_DOUT, (k == 15) ? 55 : 54);
    expect_at(20, K_UF, 1);
    expect_at(20, K_CNT, 1);
    word_in = W1;
    for (int k = 0; k < 21; k++) begin
      word_valid = (k == 6 || k == 7 || k == 9) ? 1'b0 : 1'b1;
      tick();
    end

    // Test 4: calib pulse in phase 2, then calib held across phase 4
    do_reset();
    expect_at(5, K_DOUT, slot(w4v, 0));
    expect_at(6, K_DOUT, slot(w4v, 1));
    expect_at(7, K_DOUT, slot(w4v, 2));
    expect_at(8, K_DOUT, slot(w4v, 2));
    expect_at(9, K_DOUT, slot(w4v, 3));
    expect_at(10, K_DOUT, slot(w4v, 4));
    expect_at(11, K_DOUT, slot(w4v, 0));
    expect_at(8, K_DIV, 1);
    expect_at(9, K_DIV, 0);
    expect_at(9, K_RDY, 0);
    expect_at(10, K_RDY, 1);
    expect_at(15, K_DOUT, slot(w4v, 4));
    expect_at(16, K_DOUT, slot(w4v, 4));
    expect_at(17, K_DOUT, slot(w4v, 4));
    expect_at(18, K_DOUT, slot(w4v, 0));
    expect_at(15, K_RDY, 0);
    expect_at(16, K_RDY, 0);
    expect_at(17, K_RDY, 1);
    expect_at(18, K_UF, 0);
    word_in    = W4;
    word_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      calib = (k == 7 || k == 15 || k == 16) ? 1'b1 : 1'b0;
      tick();
    end
    calib = 1'b0;

    // Test 5: 300 underflow loads saturate the counter
    do_reset();
    expect_at(5, K_CNT, 1);
    expect_at(5, K_UF, 1);
    expect_at(5 + 5*253, K_CNT, 254);
    expect_at(5 + 5*254, K_CNT, 255);
    expect_at(5 + 5*255, K_CNT, 255);
    expect_at(5 + 5*299, K_CNT, 255);
    expect_at(5 + 5*299, K_UF, 1);
    word_valid = 1'b0;
    for (int k = 0; k < 5 + 5*299 + 1; k++) tick();

    // Test 6: reset mid-word, calib during reset has no effect
    do_reset();
    expect_at(5, K_CNT, 1);
    expect_at(5, K_UF, 1);
    for (int k = 8; k < 10; k++) begin
      expect_at(k, K_DOUT, 0);
      expect_at(k, K_RDY, 0);
      expect_at(k, K_DIV, 1);
      expect_at(k, K_UF, 0);
      expect_at(k, K_CNT, 0);
    end
    expect_at(12, K_RDY, 0);
    expect_at(13, K_RDY, 1);
    expect_at(14, K_DOUT, 55);
    expect_at(14, K_CNT, 0);
    word_in = W1;
    for (int k = 0; k < 16; k++) begin
      word_valid = (k == 4) ? 1'b0 : 1'b1;
      resetn     = (k == 7 || k == 8) ? 1'b0 : 1'b1;
      calib      = (k == 8) ? 1'b1 : 1'b0;
      tick();
    end
    calib  = 1'b0;
    resetn = 1'b1;

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      drain_fail = 1'b1;
      tick();
    end
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hdmi_tx_gearbox.md
Name: hdmi_tx_gearbox

Overview:
- Soft 10:2 serialiser for the HDMI TMDS path. Runs entirely on the fast serial clock `hclkin`, which is 5x the pixel clock.
- An internal divide-by-5 phase counter requests one 10-bit TMDS word per lane every 5 cycles. Each word is then emitted as five 2-bit slots, LSB first, to the DDR output stage.
- Also produces the divide-by-5 pixel strobe and an observable divided clock.
- Supports a CALIB-style phase slip for word-boundary alignment.

Parameters:
- NUM_LANES, 3, number of TMDS lanes serialised in parallel.
- IDLE_WORD, 10'b1101010100, word loaded on underflow (TMDS control token C1C0=00).

Ports:
- hclkin  in  1  serial-rate clock (5x pixel clock).
- resetn  in  1  synchronous active-low reset, sampled on rising `hclkin`.
- word_in  in  10*NUM_LANES  lane n word at bits [10n+9:10n].
- word_valid  in  1  `word_in` holds a valid word.
- word_ready  out  1  block samples `word_in` this cycle; doubles as pixel-rate strobe.
- dout  out  2*NUM_LANES  lane n pair at bits [2n+1:2n]; bit 2n is sent first.
- div_clk  out  1  divided clock for observation only, duty 3/5.
- calib  in  1  phase-slip request, level-sensitive per cycle.
- underflow  out  1  sticky; set when a load occurs without `word_valid`.
- underflow_cnt  out  8  count of underflow loads, saturating at 255.

Behaviour:

Reset (`resetn` low at a rising edge):
- phase=0, all shift registers=0, underflow=0, underflow_cnt=0.
- Outputs while in reset: `dout`=0, `word_ready`=0, `div_clk`=1 (phase 0 decode).

Phase counter:
- 3-bit, counts 0..4 then wraps to 0.
- Advances every cycle unless `calib`=1.
- `word_ready` = (phase==4) && !calib. Combinational decode of registered state.
- `div_clk` = (phase<=2). Must not be used as a clock.

Load (cycle where `word_ready`=1):
- If `word_valid`=1: each lane's shift register <= its `word_in` slice.
- If `word_valid`=0: each lane's shift register <= IDLE_WORD; underflow <= 1; underflow_cnt increments unless already 255.
- Shift and load are exclusive per cycle: the load overwrites the shift.
- Handshake: `word_in` is consumed only when `word_ready`=1. `word_valid` in any other cycle is ignored and has no effect.

Shift (non-load cycle, `calib`=0):
- Each lane: shift <= {2'b00, shift[9:2]}.

Output and latency:
- `dout` lane n = shift_n[1:0], driven straight from the register.
- A word accepted in cycle t appears as pairs [1:0],[3:2],[5:4],[7:6],[9:8] in cycles t+1..t+5.
- The next `word_ready` is in cycle t+5, giving gapless streaming.

Calib (`calib`=1 in a cycle):
- Phase and shift registers hold.
- The `dout` pair is repeated one extra cycle and the word boundary moves one slot later.
- `word_ready` is forced 0 that cycle, so no load occurs.
- N consecutive `calib` cycles hold for N cycles.
- `calib` has no effect while `resetn` is low.

Other rules:
- Reset mid-word: the word in progress is discarded; the sequence restarts at phase 0 in the first cycle after release.
- First load after release is in cycle 4, counting the first cycle with `resetn` high as cycle 0.
- Underflow flag and counter clear only on reset.
- Lanes are fully lockstep; no per-lane state other than the shift register.

Test Plan:
1. Reset release, `word_valid`=1 constant, lane0=10'h2AB, lane1=10'h155, lane2=10'h3FF.
   - `word_ready` high in cycles 4, 9, 14, …
   - lane0 `dout` cycles 5..9 = 3,2,2,2,2; lane1 = 1,1,1,1,1; lane2 = 3,3,3,3,3.
   - `div_clk` pattern 1,1,1,0,0 repeating.
2. Stream of 4 distinct words with incrementing values.
   - Reconstructed bitstream is contiguous with no gap or duplicate slot.
   - underflow stays 0.
3. `word_valid`=0 at one `word_ready` cycle.
   - Following 5 slots per lane = 0,1,1,1,3 (IDLE_WORD LSB first).
   - underflow=1, underflow_cnt=1.
   - underflow stays 1 after valid words resume.
4. `calib` pulsed 1 cycle during phase 2.
   - Phase-2 pair repeats for 1 extra cycle.
   - `word_ready` shifts from cycle 9 to cycle 10.
   - `calib` held through phase 4: no load occurs that cycle, and the load happens on the first cycle `calib` is low.
5. 300 consecutive underflow loads → underflow_cnt saturates at 255 and does not wrap.
6. `resetn` low in cycle 7, mid-word, for 2 cycles.
   - All outputs go to 0 the following cycle, `div_clk`=1.
   - After release, the first `word_ready` is again 4 cycles later and underflow_cnt=0.
